// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding selects and ID-stage load-use stall for a 5-stage pipeline.
// Destination tags of in-flight instructions are tracked in a private EX/MEM shadow pipeline.
module hazard_forward_unit #(
    parameter int MEM_LOAD_FWD = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic [1:0]       forward_select_A,
    output logic [1:0]       forward_select_B,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    logic             ex_valid_reg;
    logic [4:0]       ex_rd_reg;
    logic             ex_wr_reg;
    logic             ex_load_reg;
    logic             mem_valid_reg;
    logic [4:0]       mem_rd_reg;
    logic             mem_wr_reg;
    logic             mem_load_reg;
    logic [1:0]       fwd_a_reg;
    logic [1:0]       fwd_b_reg;
    logic [CNT_W-1:0] stall_count_reg;

    logic             ex_valid_next;
    logic [1:0]       fwd_a_next;
    logic [1:0]       fwd_b_next;
    logic [CNT_W-1:0] stall_count_next;

    logic [4:0]       src_rs   [2];
    logic             src_used [2];
    logic             hit_ex   [2];
    logic             hit_mem  [2];
    logic [1:0]       fwd_next [2];
    logic             load_use;

    assign src_rs[0]   = id_rs1;
    assign src_rs[1]   = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // x0 is hard-wired zero, so a producer writing x0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign hit_ex[gi]  = ex_valid_reg & ex_wr_reg & (ex_rd_reg != 5'd0)
                               & (src_rs[gi] == ex_rd_reg) & src_used[gi];
            assign hit_mem[gi] = mem_valid_reg & mem_wr_reg & (mem_rd_reg != 5'd0)
                               & (src_rs[gi] == mem_rd_reg) & src_used[gi];

            // The EX producer is younger than the MEM one and so holds the live value.
            always_comb begin
                fwd_next[gi] = FWD_NONE;
                if (!id_valid || bubble_ex) begin
                    fwd_next[gi] = FWD_NONE;
                end else if (hit_ex[gi]) begin
                    fwd_next[gi] = FWD_MEM;
                end else if (hit_mem[gi]) begin
                    fwd_next[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    // With a MEM-stage load bypass the load value is available in time, so no stall is needed.
    generate
        if (MEM_LOAD_FWD == 0) begin : g_load_stall
            assign load_use = id_valid & ~flush & ex_load_reg & (hit_ex[0] | hit_ex[1]);
        end else begin : g_no_load_stall
            assign load_use = 1'b0;
        end
    endgenerate

    assign stall_id  = load_use;
    assign bubble_ex = load_use | flush;

    assign ex_valid_next = id_valid & ~bubble_ex;
    assign fwd_a_next    = fwd_next[0];
    assign fwd_b_next    = fwd_next[1];

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_id && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_reg    <= 1'b0;
            ex_rd_reg       <= 5'd0;
            ex_wr_reg       <= 1'b0;
            ex_load_reg     <= 1'b0;
            mem_valid_reg   <= 1'b0;
            mem_rd_reg      <= 5'd0;
            mem_wr_reg      <= 1'b0;
            mem_load_reg    <= 1'b0;
            fwd_a_reg       <= FWD_NONE;
            fwd_b_reg       <= FWD_NONE;
            stall_count_reg <= '0;
        end else begin
            ex_valid_reg    <= ex_valid_next;
            ex_rd_reg       <= id_rd;
            ex_wr_reg       <= id_regwrite;
            ex_load_reg     <= id_is_load;
            mem_valid_reg   <= ex_valid_reg;
            mem_rd_reg      <= ex_rd_reg;
            mem_wr_reg      <= ex_wr_reg;
            mem_load_reg    <= ex_load_reg;
            fwd_a_reg       <= fwd_a_next;
            fwd_b_reg       <= fwd_b_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign forward_select_A = fwd_a_reg;
    assign forward_select_B = fwd_b_reg;
    assign stall_count      = stall_count_reg;

    // The MEM load flag is carried for symmetry with the EX slot; nothing downstream needs it.
    logic unused_mem_load;
    assign unused_mem_load = mem_load_reg;

endmodule
